rstgen_multi: RTL

//  Multi-domain reset sequencer; parametrised successor to the board clkgen reset logic.

---
 rtl/rstgen_pkg.sv | 26 ++
 rtl/rstgen_multi_rst_sync.sv | 25 ++
 rtl/rstgen_multi.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rstgen_pkg.sv
// Shared definitions for the multi-domain reset sequencer: state encoding,
// loss-counter width and a constant clog2 helper.
package rstgen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rstgen_multi_rst_sync.sv
// Async-assert, sync-release bridge. With RST_VAL=1 and d_i=0 it is a reset
// bridge; with RST_VAL=0 and d_i as data it synchronises a level input.
module rst_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rstgen_multi.sv
// Multi-domain reset sequencer: filters PLL/DCM locks, stretches reset, then
// releases the wb reset and each domain reset in index order.
module rstgen_multi
  import rstgen_pkg::*;
#(
  parameter int NUM_LOCKS      = 2,
  parameter int NUM_DOMAINS    = 3,
  parameter int LOCK_FILTER    = 8,
  parameter int STRETCH_CYCLES = 16,
  parameter int RELEASE_GAP    = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   wb_clk_o,
  input  logic                   async_rst_n,
  input  logic [NUM_LOCKS-1:0]   lock_i,
  input  logic [NUM_DOMAINS-1:0] dom_clk_i,
  input  logic                   sw_rst_req_i,
  output logic                   wb_rst_o,
  output logic [NUM_DOMAINS-1:0] dom_rst_o,
  output logic                   rst_done_o,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt_o
);

  localparam int MAX_A = (LOCK_FILTER > STRETCH_CYCLES) ? LOCK_FILTER : STRETCH_CYCLES;
  localparam int MAX_CNT = (MAX_A > RELEASE_GAP) ? MAX_A : RELEASE_GAP;
  localparam int CNT_W = clog2(MAX_CNT) + 1;
  localparam int IDX_W = (NUM_DOMAINS > 1) ? clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] LF_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] SC_LAST  = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RG_LAST  = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_DOMAINS-1:0]  hold_q;
  logic                    wbRst_q;
  logic                    done_q;
  logic [LOSS_CNT_W-1:0]   lossCnt_q;
  logic [NUM_LOCKS-1:0]    locksSynced;
  logic                    locksOk;

  for (genvar l = 0; l < NUM_LOCKS; l++) begin : g_lock_sync
    rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
      .clk_i  (wb_clk_o),
      .arst_i (~async_rst_n),
      .d_i    (lock_i[l]),
      .q_o    (locksSynced[l])
    );
  end

  assign locksOk = &locksSynced;

  // Loss of lock outside WAIT_LOCK pre-empts every other transition.
  always_ff @(posedge wb_clk_o or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '1;
      wbRst_q   <= 1'b1;
      done_q    <= 1'b0;
      lossCnt_q <= '0;
    end else if (state_q != WAIT_LOCK && !locksOk) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '1;
      wbRst_q <= 1'b1;
      done_q  <= 1'b0;
      if (state_q == RUN && lossCnt_q != '1) begin
        lossCnt_q <= lossCnt_q + LOSS_CNT_W'(1);
      end
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!locksOk) begin
            cnt_q <= '0;
          end else if (cnt_q == LF_LAST) begin
            state_q <= STRETCH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STRETCH: begin
          if (cnt_q == SC_LAST) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wbRst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == RG_LAST) begin
            hold_q[idx_q] <= 1'b0;
            cnt_q         <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (sw_rst_req_i) begin
            state_q <= STRETCH;
            cnt_q   <= '0;
            hold_q  <= '1;
            wbRst_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom_sync
    rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_dom_sync (
      .clk_i  (dom_clk_i[d]),
      .arst_i (hold_q[d] | ~async_rst_n),
      .d_i    (1'b0),
      .q_o    (dom_rst_o[d])
    );
  end

  assign wb_rst_o        = wbRst_q;
  assign rst_done_o      = done_q;
  assign lock_loss_cnt_o = lossCnt_q;

endmodule
